// File: rtl/nibble_serial_sub_if.sv
// Start/done handshake bundle for the nibble-serial subtractor.
interface nibble_serial_sub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r;
    logic             bo;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output start, a, b, bi,
        input  busy, done, r, bo, zero, neg, ovf
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, r, bo, zero, neg, ovf
    );
endinterface

// File: rtl/nibble_serial_sub.sv
// Multi-cycle a - b - bi: one 4-bit carry-lookahead slice reused per nibble,
// carry registered between nibbles. WIDTH must be a multiple of 4 and >= 4.
module nibble_serial_sub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_serial_sub_if.slave  bus
);
    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = CW + 2;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic             accept;
    logic [WIDTH-1:0] a_q, b_q, r_q, r_nx;
    logic [CW-1:0]    count;
    logic [SW-1:0]    shamt;
    logic             c_q;
    logic             busy_q, done_q, bo_q, zero_q, neg_q, ovf_q;
    logic [3:0]       an, bn, p, g, sum;
    logic             c1, c2, c3, c4;

    // State register; busy/done registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            busy_q <= (state_n == RUN);
            done_q <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = RUN;
                    accept  = 1'b1;
                end
            end
            RUN: begin
                if (count == LAST) state_n = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    state_n = RUN;
                    accept  = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // CLA slice on the low nibble of the shifting operands: a + ~b + c
    always_comb begin
        an    = a_q[3:0];
        bn    = ~b_q[3:0];
        p     = an ^ bn;
        g     = an & bn;
        c1    = g[0] | (p[0] & c_q);
        c2    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
        c3    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
        c4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_q);
        sum   = p ^ {c3, c2, c1, c_q};
        shamt = {count, 2'b00};
        r_nx  = (r_q & ~(WIDTH'(4'hF) << shamt)) | (WIDTH'(sum) << shamt);
    end

    // Operand capture, per-nibble result write, flags only on the last nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            count  <= '0;
            r_q    <= '0;
            bo_q   <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            c_q   <= ~bus.bi;
            count <= '0;
        end else if (state == RUN) begin
            a_q   <= a_q >> 4;
            b_q   <= b_q >> 4;
            c_q   <= c4;
            r_q   <= r_nx;
            count <= count + CW'(1);
            if (count == LAST) begin
                bo_q   <= ~c4;
                zero_q <= (r_nx == '0);
                neg_q  <= sum[3];
                ovf_q  <= c3 ^ c4;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.r    = r_q;
    assign bus.bo   = bo_q;
    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub at WIDTH=16 and WIDTH=4, scoreboard based.
module tb_nibble_serial_sub;
    typedef struct packed {
        logic [15:0] r;
        logic        bo;
        logic        zero;
        logic        neg;
        logic        ovf;
    } res_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    res_t exp_q[$];

    nibble_serial_sub_if #(.WIDTH(16)) i16 ();
    nibble_serial_sub_if #(.WIDTH(4))  i4 ();

    nibble_serial_sub #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));
    nibble_serial_sub #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(i4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: unsigned difference for r/bo, signed range test for ovf
    function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic bi);
        longint m, ua, ub, d, sa, sb, s, half, rr;
        res_t   e;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        d    = ua - ub - longint'(bi);
        rr   = d & m;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        s    = sa - sb - longint'(bi);
        e.r    = 16'(rr);
        e.bo   = (d < 0);
        e.zero = (rr == 0);
        e.neg  = 1'((rr >> (w - 1)) & 1);
        e.ovf  = (s >= half) || (s < -half);
        return e;
    endfunction

    function automatic res_t sample(input int w);
        res_t o;
        if (w == 16) begin
            o.r = i16.r; o.bo = i16.bo; o.zero = i16.zero; o.neg = i16.neg; o.ovf = i16.ovf;
        end else begin
            o.r = 16'(i4.r); o.bo = i4.bo; o.zero = i4.zero; o.neg = i4.neg; o.ovf = i4.ovf;
        end
        return o;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 16) ? i16.done : i4.done;
    endfunction

    // Pulse start for one cycle, push the expectation, wait (bounded) for done
    task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic bi, output res_t obs, output int lat);
        @(negedge clk);
        if (w == 16) begin
            i16.a = a; i16.b = b; i16.bi = bi; i16.start = 1'b1;
        end else begin
            i4.a = a[3:0]; i4.b = b[3:0]; i4.bi = bi; i4.start = 1'b1;
        end
        exp_q.push_back(model(w, a, b, bi));
        @(negedge clk);
        i16.start = 1'b0;
        i4.start  = 1'b0;
        lat = 1;
        while (!done_of(w) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        obs = sample(w);
    endtask

    task automatic pop_check(input string name, input res_t obs, input int lat, input int want_lat);
        res_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty, got %h", name, obs);
            return;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) $display("FAIL %s result: got %h want %h", name, obs, e);
        else n_pass++;
        n_checks++;
        if (lat !== want_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, want_lat);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i16.start = 1'b0; i16.a = '0; i16.b = '0; i16.bi = 1'b0;
        i4.start  = 1'b0; i4.a  = '0; i4.b  = '0; i4.bi  = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({i16.busy, i16.done, i16.r, i16.bo, i16.zero, i16.neg, i16.ovf} !== 23'd0)
            $display("FAIL reset16: got %b want 0",
                     {i16.busy, i16.done, i16.r, i16.bo, i16.zero, i16.neg, i16.ovf});
        else n_pass++;
        n_checks++;
        if ({i4.busy, i4.done, i4.r, i4.bo, i4.zero, i4.neg, i4.ovf} !== 11'd0)
            $display("FAIL reset4: got %b want 0",
                     {i4.busy, i4.done, i4.r, i4.bo, i4.zero, i4.neg, i4.ovf});
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({i16.busy, i16.done} !== 2'b00)
            $display("FAIL idle_after_reset: got %b want 00", {i16.busy, i16.done});
        else n_pass++;
    endtask

    task automatic test_basic();
        res_t o;
        int   lat;
        do_op(16, 16'h000A, 16'h0001, 1'b0, o, lat);
        n_checks++;
        if (o.r !== 16'h0009) $display("FAIL basic_r: got %h want 0009", o.r);
        else n_pass++;
        pop_check("basic", o, lat, 5);
        @(negedge clk);
        n_checks++;
        if ({i16.done, i16.r} !== {1'b0, 16'h0009})
            $display("FAIL hold_after_done: got %b/%h want 0/0009", i16.done, i16.r);
        else n_pass++;
    endtask

    task automatic test_flags();
        res_t o;
        int   lat;
        do_op(16, 16'h0000, 16'h0001, 1'b0, o, lat);
        pop_check("borrow_neg", o, lat, 5);
        do_op(16, 16'h8000, 16'h0001, 1'b0, o, lat);
        n_checks++;
        if ({o.r, o.ovf, o.bo} !== {16'h7FFF, 1'b1, 1'b0})
            $display("FAIL ovf_lit: got %h/%b/%b want 7fff/1/0", o.r, o.ovf, o.bo);
        else n_pass++;
        pop_check("overflow", o, lat, 5);
        do_op(16, 16'h0005, 16'h0005, 1'b1, o, lat);
        pop_check("borrow_in", o, lat, 5);
        do_op(16, 16'h1234, 16'h1234, 1'b0, o, lat);
        n_checks++;
        if ({o.r, o.zero} !== {16'h0000, 1'b1})
            $display("FAIL zero_lit: got %h/%b want 0000/1", o.r, o.zero);
        else n_pass++;
        pop_check("zero", o, lat, 5);
    endtask

    task automatic test_back_to_back();
        res_t o;
        int   cnt;
        @(negedge clk);
        i16.a = 16'h00FF; i16.b = 16'h000F; i16.bi = 1'b0; i16.start = 1'b1;
        exp_q.push_back(model(16, 16'h00FF, 16'h000F, 1'b0));
        @(negedge clk);
        i16.start = 1'b0;
        @(negedge clk);
        i16.a = 16'h0000; i16.b = 16'h0001; i16.start = 1'b1;
        n_checks++;
        if (i16.busy !== 1'b1) $display("FAIL busy_mid: got %b want 1", i16.busy);
        else n_pass++;
        @(negedge clk);
        i16.start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (i16.done !== 1'b1) $display("FAIL ignored_done: got %b want 1", i16.done);
        else n_pass++;
        o = sample(16);
        n_checks++;
        if (o.r !== 16'h00F0) $display("FAIL ignored_r: got %h want 00f0", o.r);
        else n_pass++;
        pop_check("ignored_start", o, 5, 5);
        i16.a = 16'h1234; i16.b = 16'h0234; i16.bi = 1'b1; i16.start = 1'b1;
        exp_q.push_back(model(16, 16'h1234, 16'h0234, 1'b1));
        @(negedge clk);
        i16.start = 1'b0;
        n_checks++;
        if ({i16.busy, i16.done} !== 2'b10)
            $display("FAIL b2b_busy: got %b want 10", {i16.busy, i16.done});
        else n_pass++;
        cnt = 0;
        while (!i16.done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        pop_check("back_to_back", sample(16), cnt, 4);
    endtask

    task automatic test_reset_mid_run();
        res_t o;
        int   lat;
        bit   seen_done;
        @(negedge clk);
        i16.a = 16'h00FF; i16.b = 16'h0001; i16.bi = 1'b0; i16.start = 1'b1;
        @(negedge clk);
        i16.start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (i16.busy !== 1'b1) $display("FAIL pre_abort_busy: got %b want 1", i16.busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({i16.busy, i16.done, i16.r, i16.bo, i16.zero, i16.neg, i16.ovf} !== 23'd0)
            $display("FAIL abort_outputs: got %b want 0",
                     {i16.busy, i16.done, i16.r, i16.bo, i16.zero, i16.neg, i16.ovf});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (i16.done) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0) $display("FAIL abort_no_done: got %b want 0", seen_done);
        else n_pass++;
        do_op(16, 16'h0003, 16'h0002, 1'b0, o, lat);
        n_checks++;
        if (o.r !== 16'h0001) $display("FAIL post_reset_r: got %h want 0001", o.r);
        else n_pass++;
        pop_check("post_reset", o, lat, 5);
    endtask

    task automatic test_width4();
        res_t o;
        int   lat;
        do_op(4, 16'h000A, 16'h0001, 1'b0, o, lat);
        n_checks++;
        if (o.r !== 16'h0009) $display("FAIL w4_r: got %h want 0009", o.r);
        else n_pass++;
        pop_check("w4_basic", o, lat, 2);
    endtask

    task automatic test_random();
        res_t o;
        int   lat;
        logic [15:0] a, b;
        logic        bi;
        for (int i = 0; i < 24; i++) begin
            a  = 16'($urandom);
            b  = (i % 6 == 0) ? a : 16'($urandom);
            bi = 1'($urandom_range(0, 1));
            do_op(16, a, b, bi, o, lat);
            pop_check("rand16", o, lat, 5);
        end
        for (int i = 0; i < 24; i++) begin
            a  = 16'($urandom_range(0, 15));
            b  = 16'($urandom_range(0, 15));
            bi = 1'($urandom_range(0, 1));
            do_op(4, a, b, bi, o, lat);
            pop_check("rand4", o, lat, 2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_back_to_back();
        test_reset_mid_run();
        test_width4();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
